// File: rtl/ray_trig_nearest_hit.sv
`default_nettype none
// ============================================================================
// Module   : ray_trig_nearest_hit
// Purpose  : Multi-cycle ray/triangle nearest-hit unit. Accepts one ray,
//            streams up to MAX_TRIG triangles from a synchronous scene
//            memory, and runs a division-free Moller-Trumbore test on each
//            one. It reports the closest hit with distance in (EPS, T_MAX).
//            A single restoring division at the end converts the best
//            (t_n, det) pair into a fixed-point distance.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     ray handshake
//   ray_in [6*WIDTH]        {start.x,y,z, dir.x,y,z}, MSB first
//   trig_count [IDX_W+1]    triangles to scan, clamped to MAX_TRIG
//   trig_rd_en / trig_addr  scene memory read; data returns next cycle
//   trig_data [9*WIDTH]     {v1,v2,v3}, each {x,y,z}
//   out_valid / out_ready   result handshake
//   hit, hit_idx, hit_t     result (hit_t is 0 on a miss)
// Configuration macro
//   RAY_TRIG_BACKFACE_CULL_EN : single-sided test (reject det <= EPS_RAW)
// ============================================================================
module ray_trig_nearest_hit #(
  parameter  int WIDTH     = 32,
  parameter  int FRAC      = 16,
  parameter  int MAX_TRIG  = 16,
  parameter  int EPS_RAW   = 66,
  parameter  int T_MAX_RAW = 32'h0002_0000,
  localparam int IDX_W     = (MAX_TRIG > 1) ? $clog2(MAX_TRIG) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6*WIDTH-1:0]   ray_in,
  input  logic [IDX_W:0]       trig_count,
  output logic                 trig_rd_en,
  output logic [IDX_W-1:0]     trig_addr,
  input  logic [9*WIDTH-1:0]   trig_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [WIDTH-1:0]     hit_t
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic signed [WIDTH-1:0] c_eps   = WIDTH'(EPS_RAW);
  localparam logic signed [WIDTH-1:0] c_tmax  = WIDTH'(T_MAX_RAW);
  localparam logic [IDX_W:0]          c_max_n = (IDX_W + 1)'(MAX_TRIG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CROSS = 3'd2,
    S_TEST  = 3'd3,
    S_DIV   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  // Fixed-point multiply: full signed product, arithmetic shift, truncate.
  function automatic logic signed [WIDTH-1:0] fmul(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] prod;
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    return prod[FRAC +: WIDTH];
  endfunction

  // Latched ray and scan bookkeeping
  logic signed [WIDTH-1:0] r_org [3];
  logic signed [WIDTH-1:0] r_dir [3];
  logic [IDX_W:0]          r_n;
  logic [IDX_W:0]          r_idx;

  // Per-triangle registered numerators
  logic signed [WIDTH-1:0] r_det, r_un, r_vn, r_tn;

  // Best candidate so far
  logic                    r_any;
  logic signed [WIDTH-1:0] r_best_tn, r_best_det;
  logic [IDX_W-1:0]        r_best_idx;

  // Divider
  logic [WIDTH-1:0]        r_rem, r_quo;
  logic [CNT_W-1:0]        r_cnt;

  // Output registers
  logic                    r_hit;
  logic [IDX_W-1:0]        r_hit_idx;
  logic [WIDTH-1:0]        r_hit_t;

  logic [IDX_W:0]          w_n_clamp;
  assign w_n_clamp = (trig_count > c_max_n) ? c_max_n : trig_count;

  // --------------------------------------------------------------------------
  // CROSS-stage arithmetic, straight from the memory read data
  // --------------------------------------------------------------------------
  logic signed [WIDTH-1:0] w_v1 [3], w_v2 [3], w_v3 [3];
  logic signed [WIDTH-1:0] w_e1 [3], w_e2 [3], w_t1 [3];
  logic signed [WIDTH-1:0] w_p  [3], w_q  [3];
  logic signed [WIDTH-1:0] w_det, w_un, w_vn, w_tn;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_v1[k] = trig_data[(9-k)*WIDTH-1 -: WIDTH];
      w_v2[k] = trig_data[(6-k)*WIDTH-1 -: WIDTH];
      w_v3[k] = trig_data[(3-k)*WIDTH-1 -: WIDTH];
      w_e1[k] = w_v2[k] - w_v1[k];
      w_e2[k] = w_v3[k] - w_v1[k];
      w_t1[k] = r_org[k] - w_v1[k];
    end
    // p = dir x e2
    w_p[0] = fmul(r_dir[1], w_e2[2]) - fmul(r_dir[2], w_e2[1]);
    w_p[1] = fmul(r_dir[2], w_e2[0]) - fmul(r_dir[0], w_e2[2]);
    w_p[2] = fmul(r_dir[0], w_e2[1]) - fmul(r_dir[1], w_e2[0]);
    // q = t1 x e1
    w_q[0] = fmul(w_t1[1], w_e1[2]) - fmul(w_t1[2], w_e1[1]);
    w_q[1] = fmul(w_t1[2], w_e1[0]) - fmul(w_t1[0], w_e1[2]);
    w_q[2] = fmul(w_t1[0], w_e1[1]) - fmul(w_t1[1], w_e1[0]);

    w_det = fmul(w_p[0], w_e1[0]) + fmul(w_p[1], w_e1[1]) + fmul(w_p[2], w_e1[2]);
    w_un  = fmul(w_t1[0], w_p[0]) + fmul(w_t1[1], w_p[1]) + fmul(w_t1[2], w_p[2]);
    w_vn  = fmul(r_dir[0], w_q[0]) + fmul(r_dir[1], w_q[1]) + fmul(r_dir[2], w_q[2]);
    w_tn  = fmul(w_e2[0], w_q[0]) + fmul(w_e2[1], w_q[1]) + fmul(w_e2[2], w_q[2]);

`ifdef RAY_TRIG_BACKFACE_CULL_EN
    // Single-sided: keep the raw sign so back faces fail the det > EPS test.
`else
    // Two-sided: fold back faces onto the front-facing sign convention.
    if (w_det[WIDTH-1]) begin
      w_det = -w_det;
      w_un  = -w_un;
      w_vn  = -w_vn;
      w_tn  = -w_tn;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // TEST-stage acceptance and nearest selection
  // --------------------------------------------------------------------------
  logic                      w_accept, w_better, w_take, w_last, w_any_nxt;
  logic signed [WIDTH-1:0]   w_uv, w_best_tn_nxt;
  logic signed [2*WIDTH-1:0] w_lhs, w_rhs;
  logic [2*WIDTH-1:0]        w_dvd;
  logic [IDX_W:0]            w_idx_inc;

  always_comb begin
    w_uv     = r_un + r_vn;
    w_accept = (r_det > c_eps) &&
               !r_un[WIDTH-1] && (r_un <= r_det) &&
               !r_vn[WIDTH-1] && (w_uv <= r_det) &&
               (r_tn > fmul(c_eps, r_det)) &&
               (r_tn < fmul(c_tmax, r_det));
    // Compare t_n/det against best_tn/best_det by cross-multiplying; both
    // dets are positive here. Strict '<' keeps the lower index on a tie.
    w_lhs    = (2*WIDTH)'(r_tn) * (2*WIDTH)'(r_best_det);
    w_rhs    = (2*WIDTH)'(r_best_tn) * (2*WIDTH)'(r_det);
    w_better = !r_any || (w_lhs < w_rhs);
    w_take   = w_accept && w_better;
    w_any_nxt     = r_any || w_take;
    w_best_tn_nxt = w_take ? r_tn : r_best_tn;
    // Dividend best_tn << FRAC; its upper half is already below the divisor,
    // so WIDTH quotient bits are enough.
    w_dvd     = {{WIDTH{1'b0}}, w_best_tn_nxt} << FRAC;
    w_idx_inc = r_idx + 1'b1;
    w_last    = (w_idx_inc == r_n);
  end

  // Restoring division step
  logic [WIDTH:0] w_rem_sh, w_rem_sub;
  logic           w_ge;

  always_comb begin
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_rem_sub = w_rem_sh - {1'b0, r_best_det};
    w_ge      = (w_rem_sh >= {1'b0, r_best_det});
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    trig_rd_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        trig_rd_en  = 1'b1;
        w_state_nxt = S_CROSS;
      end
      S_CROSS: w_state_nxt = S_TEST;
      S_TEST: begin
        if (w_last) w_state_nxt = w_any_nxt ? S_DIV : S_DONE;
        else        w_state_nxt = S_READ;
      end
      S_DIV: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        r_org[k] <= '0;
        r_dir[k] <= '0;
      end
      r_n        <= '0;
      r_idx      <= '0;
      r_det      <= '0;
      r_un       <= '0;
      r_vn       <= '0;
      r_tn       <= '0;
      r_any      <= 1'b0;
      r_best_tn  <= '0;
      r_best_det <= '0;
      r_best_idx <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_hit_t    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
              r_org[k] <= ray_in[(6-k)*WIDTH-1 -: WIDTH];
              r_dir[k] <= ray_in[(3-k)*WIDTH-1 -: WIDTH];
            end
            r_n        <= w_n_clamp;
            r_idx      <= '0;
            r_any      <= 1'b0;
            r_best_tn  <= '0;
            r_best_det <= '0;
            r_best_idx <= '0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_hit_t    <= '0;
          end
        end
        S_CROSS: begin
          r_det <= w_det;
          r_un  <= w_un;
          r_vn  <= w_vn;
          r_tn  <= w_tn;
        end
        S_TEST: begin
          if (w_take) begin
            r_any      <= 1'b1;
            r_best_tn  <= r_tn;
            r_best_det <= r_det;
            r_best_idx <= r_idx[IDX_W-1:0];
          end
          r_idx <= w_idx_inc;
          r_rem <= w_dvd[2*WIDTH-1:WIDTH];
          r_quo <= w_dvd[WIDTH-1:0];
          r_cnt <= '0;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_best_idx;
            r_hit_t   <= {r_quo[WIDTH-2:0], w_ge};
          end
        end
        default: ;
      endcase
    end
  end

  assign trig_addr = r_idx[IDX_W-1:0];
  assign hit       = r_hit;
  assign hit_idx   = r_hit_idx;
  assign hit_t     = r_hit_t;

endmodule
`default_nettype wire

// File: tb/tb_ray_trig_nearest_hit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_trig_nearest_hit
// Purpose  : Self-checking bench for ray_trig_nearest_hit: directed scenes
//            plus randomized scenes checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_trig_nearest_hit;

  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam int MAXT = 16;
  localparam int IW   = 4;
  localparam int EPS  = 66;
  localparam int TMAX = 32'h0002_0000;
  localparam int ONE  = 65536;
`ifdef RAY_TRIG_BACKFACE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6*W-1:0]  ray_in = '0;
  logic [IW:0]     trig_count = '0;
  logic            trig_rd_en;
  logic [IW-1:0]   trig_addr;
  logic [9*W-1:0]  trig_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [W-1:0]    hit_t;

  int checks = 0;
  int fails  = 0;

  ray_trig_nearest_hit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ray_in     (ray_in),
    .trig_count (trig_count),
    .trig_rd_en (trig_rd_en),
    .trig_addr  (trig_addr),
    .trig_data  (trig_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_t      (hit_t)
  );

  always #5 clk = ~clk;

  // Synchronous scene memory; garbage on idle cycles exposes mistimed sampling.
  logic [9*W-1:0] mem [MAXT];
  always @(posedge clk) begin
    if (trig_rd_en) trig_data <= mem[trig_addr];
    else trig_data <= {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
  end

  // Scene description shared by stimulus and model
  int g_org [3];
  int g_dir [3];
  int g_tri [MAXT][9];

  function automatic int rj(int r);
    return int'($urandom_range(2 * r, 0)) - r;
  endfunction

  function automatic int fm(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> FRAC);
  endfunction

  // Reference: nearest accepted triangle among the first n.
  function automatic void model_scan(input int n, output bit h, output int idx, output int t);
    int e1 [3], e2 [3], s [3], p [3], q [3];
    int det, un, vn, tn;
    longint btn, bdet;
    h = 1'b0; idx = 0; t = 0; btn = 0; bdet = 1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        e1[k] = g_tri[i][3+k] - g_tri[i][k];
        e2[k] = g_tri[i][6+k] - g_tri[i][k];
        s[k]  = g_org[k] - g_tri[i][k];
      end
      for (int k = 0; k < 3; k++) begin
        p[k] = fm(g_dir[(k+1)%3], e2[(k+2)%3]) - fm(g_dir[(k+2)%3], e2[(k+1)%3]);
        q[k] = fm(s[(k+1)%3], e1[(k+2)%3]) - fm(s[(k+2)%3], e1[(k+1)%3]);
      end
      det = 0; un = 0; vn = 0; tn = 0;
      for (int k = 0; k < 3; k++) begin
        det += fm(p[k], e1[k]);
        un  += fm(s[k], p[k]);
        vn  += fm(g_dir[k], q[k]);
        tn  += fm(e2[k], q[k]);
      end
      if (!CULL && det < 0) begin
        det = -det; un = -un; vn = -vn; tn = -tn;
      end
      if (det > EPS && un >= 0 && un <= det && vn >= 0 && (un + vn) <= det &&
          tn > fm(EPS, det) && tn < fm(TMAX, det)) begin
        if (!h || longint'(tn) * bdet < btn * longint'(det)) begin
          h = 1'b1; idx = i; btn = tn; bdet = det;
        end
      end
    end
    if (h) t = int'((btn <<< FRAC) / bdet);
  endfunction

  task automatic set_ray(input int ox, oy, oz, dx, dy, dz);
    g_org[0] = ox; g_org[1] = oy; g_org[2] = oz;
    g_dir[0] = dx; g_dir[1] = dy; g_dir[2] = dz;
  endtask

  task automatic set_tri(input int i, input int ax, ay, az, bx, by, bz, cx, cy, cz);
    g_tri[i][0] = ax; g_tri[i][1] = ay; g_tri[i][2] = az;
    g_tri[i][3] = bx; g_tri[i][4] = by; g_tri[i][5] = bz;
    g_tri[i][6] = cx; g_tri[i][7] = cy; g_tri[i][8] = cz;
  endtask

  task automatic load_scene();
    for (int i = 0; i < MAXT; i++)
      for (int j = 0; j < 9; j++)
        mem[i][(9-j)*W-1 -: W] = g_tri[i][j];
  endtask

  task automatic pack_ray(input int n);
    for (int k = 0; k < 3; k++) begin
      ray_in[(6-k)*W-1 -: W] = g_org[k];
      ray_in[(3-k)*W-1 -: W] = g_dir[k];
    end
    trig_count = 5'(n);
  endtask

  // Runs one transaction; entered and left #1 after a rising edge.
  // lat counts edges from the accept edge until out_valid is seen.
  task automatic run_ray(input int n, output bit oh, output int oidx, output int ot,
                         output int lat, output bit to);
    int k;
    to = 1'b0; lat = 0; k = 0;
    load_scene();
    pack_ray(n);
    out_ready = 1'b1;
    while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) to = 1'b1;
    oh = hit; oidx = int'(hit_idx); ot = int'(hit_t);
    @(posedge clk); #1;
  endtask

  task automatic scene_front();
    set_ray(0, 0, -ONE, 0, 0, ONE);
    set_tri(0, -ONE, -ONE, 0, 0, ONE, 0, ONE, -ONE, 0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (hit !== 1'b0) begin fails++; $display("FAIL reset_hit got=%0b exp=0", hit); end
    checks++; if (hit_idx !== '0) begin fails++; $display("FAIL reset_hit_idx got=%0d exp=0", hit_idx); end
    checks++; if (hit_t !== '0) begin fails++; $display("FAIL reset_hit_t got=%0h exp=0", hit_t); end
    checks++; if (trig_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%0b exp=0", trig_rd_en); end
    checks++; if (trig_addr !== '0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", trig_addr); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_front();
    bit h, to; int idx, t, lat;
    scene_front();
    run_ray(1, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL front_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== 1'b1) begin fails++; $display("FAIL front_hit got=%0b exp=1", h); end
    checks++; if (idx != 0) begin fails++; $display("FAIL front_idx got=%0d exp=0", idx); end
    checks++; if (t != 32'h0001_0000) begin fails++; $display("FAIL front_t got=%0h exp=10000", t); end
    checks++; if (lat + 1 != 3 + W + 1) begin fails++; $display("FAIL front_latency got=%0d exp=%0d", lat + 1, 3 + W + 1); end
  endtask

  task automatic test_nearest();
    bit h, to; int idx, t, lat;
    set_ray(0, 0, -ONE, 0, 0, ONE);
    set_tri(0, -ONE, -ONE, ONE/2, 0, ONE, ONE/2, ONE, -ONE, ONE/2);
    set_tri(1, -ONE, -ONE, 0, 0, ONE, 0, ONE, -ONE, 0);
    set_tri(2, -ONE, -ONE, 0, 0, ONE, 0, ONE, -ONE, 0);
    run_ray(3, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL nearest_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== 1'b1) begin fails++; $display("FAIL nearest_hit got=%0b exp=1", h); end
    checks++; if (idx != 1) begin fails++; $display("FAIL nearest_idx got=%0d exp=1", idx); end
    checks++; if (t != 32'h0001_0000) begin fails++; $display("FAIL nearest_t got=%0h exp=10000", t); end
    checks++; if (lat + 1 != 9 + W + 1) begin fails++; $display("FAIL nearest_latency got=%0d exp=%0d", lat + 1, 9 + W + 1); end
  endtask

  task automatic test_parallel();
    bit h, to; int idx, t, lat;
    scene_front();
    set_ray(0, 0, -ONE, ONE, 0, 0);
    run_ray(1, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL parallel_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL parallel_hit got=%0b exp=0", h); end
    checks++; if (t != 0) begin fails++; $display("FAIL parallel_t got=%0h exp=0", t); end
    checks++; if (lat + 1 != 4) begin fails++; $display("FAIL parallel_latency got=%0d exp=4", lat + 1); end
  endtask

  task automatic test_backface();
    bit h, to; int idx, t, lat;
    set_ray(0, 0, -ONE, 0, 0, ONE);
    set_tri(0, -ONE, -ONE, 0, ONE, -ONE, 0, 0, ONE, 0);
    run_ray(1, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL backface_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== !CULL) begin fails++; $display("FAIL backface_hit got=%0b exp=%0b", h, !CULL); end
    checks++; if (t != (CULL ? 0 : 32'h0001_0000)) begin fails++; $display("FAIL backface_t got=%0h exp=%0h", t, (CULL ? 0 : 32'h0001_0000)); end
  endtask

  task automatic test_range();
    bit h, to; int idx, t, lat;
    set_ray(0, 0, -ONE, 0, 0, ONE);
    set_tri(0, -ONE, -ONE, 3*ONE/2, 0, ONE, 3*ONE/2, ONE, -ONE, 3*ONE/2);
    run_ray(1, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL range_far_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL range_far_hit got=%0b exp=0", h); end
    checks++; if (t != 0) begin fails++; $display("FAIL range_far_t got=%0h exp=0", t); end
    scene_front();
    run_ray(0, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL range_n0_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL range_n0_hit got=%0b exp=0", h); end
    checks++; if (lat + 1 != 1) begin fails++; $display("FAIL range_n0_latency got=%0d exp=1", lat + 1); end
  endtask

  task automatic test_random();
    bit h, to, mh; int idx, t, lat, midx, mt, n, nc, z, jx, jy, jz, elat;
    for (int it = 0; it < 30; it++) begin
      set_ray(rj(ONE/4), rj(ONE/4), -ONE, rj(ONE/8), rj(ONE/8), ONE);
      for (int i = 0; i < MAXT; i++) begin
        if (i > 0 && $urandom_range(3, 0) == 0) begin
          for (int j = 0; j < 9; j++) g_tri[i][j] = g_tri[i-1][j];
        end else begin
          z = rj(ONE) + ONE/2;
          jx = rj(ONE/4); jy = rj(ONE/4); jz = rj(ONE/4);
          set_tri(i, -ONE + jx, -ONE + jy, z + jz, jy, ONE + jx, z - jz,
                  ONE + jy, -ONE + jz, z + jx);
          if ($urandom_range(1, 0) == 1)
            for (int j = 0; j < 3; j++) begin
              z = g_tri[i][3+j]; g_tri[i][3+j] = g_tri[i][6+j]; g_tri[i][6+j] = z;
            end
        end
      end
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = int'($urandom_range(31, 17));
        default: n = int'($urandom_range(MAXT, 1));
      endcase
      nc = (n > MAXT) ? MAXT : n;
      model_scan(nc, mh, midx, mt);
      run_ray(n, h, idx, t, lat, to);
      elat = (nc == 0) ? 0 : 3 * nc + (mh ? W : 0);
      checks++; if (to) begin fails++; $display("FAIL rand_timeout it=%0d got=timeout exp=out_valid", it); end
      checks++; if (h !== mh) begin fails++; $display("FAIL rand_hit it=%0d got=%0b exp=%0b", it, h, mh); end
      checks++; if (idx != midx) begin fails++; $display("FAIL rand_idx it=%0d got=%0d exp=%0d", it, idx, midx); end
      checks++; if (t != mt) begin fails++; $display("FAIL rand_t it=%0d got=%0h exp=%0h", it, t, mt); end
      checks++; if (lat != elat) begin fails++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat + 1, elat + 1); end
    end
  endtask

  task automatic test_handshake();
    int k;
    scene_front();
    load_scene();
    pack_ray(1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep offering a different ray the whole time; it must be ignored.
    set_ray(0, 0, -ONE, ONE, 0, 0);
    pack_ray(0);
    k = 0;
    while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
    checks++; if (!out_valid) begin fails++; $display("FAIL hs_timeout got=timeout exp=out_valid"); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || hit !== 1'b1 || hit_idx !== '0 || hit_t !== 32'h0001_0000) begin
        fails++;
        $display("FAIL hs_hold c=%0d got=v%0b r%0b h%0b i%0d t%0h exp=v1 r0 h1 i0 t10000",
                 c, out_valid, in_ready, hit, hit_idx, hit_t);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hs_release_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hs_release_ready got=%0b exp=1", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit h, to; int idx, t, lat, k;
    set_ray(0, 0, -ONE, 0, 0, ONE);
    set_tri(0, -ONE, -ONE, ONE/2, 0, ONE, ONE/2, ONE, -ONE, ONE/2);
    set_tri(1, -ONE, -ONE, 0, 0, ONE, 0, ONE, -ONE, 0);
    set_tri(2, -ONE, -ONE, 0, 0, ONE, 0, ONE, -ONE, 0);
    load_scene();
    pack_ray(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!(trig_rd_en && trig_addr == 4'd1) && k < 50) begin @(posedge clk); #1; k++; end
    checks++; if (k >= 50) begin fails++; $display("FAIL abort_wait got=timeout exp=read_of_idx1"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got=%0b exp=1", in_ready); end
    checks++; if (trig_rd_en !== 1'b0 || hit !== 1'b0 || hit_t !== '0) begin
      fails++; $display("FAIL abort_outputs got=rd%0b h%0b t%0h exp=rd0 h0 t0", trig_rd_en, hit, hit_t);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    scene_front();
    run_ray(1, h, idx, t, lat, to);
    checks++; if (to) begin fails++; $display("FAIL abort_next_timeout got=timeout exp=out_valid"); end
    checks++; if (h !== 1'b1 || t != 32'h0001_0000) begin fails++; $display("FAIL abort_next got=h%0b t%0h exp=h1 t10000", h, t); end
  endtask

  initial begin
    for (int i = 0; i < MAXT; i++) for (int j = 0; j < 9; j++) g_tri[i][j] = 0;
    test_reset();
    test_front();
    test_nearest();
    test_parallel();
    test_backface();
    test_range();
    test_random();
    test_handshake();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
